pwm_timer_mc: RTL and testbench

//  Multi-channel PWM timer; next generation of the single-channel PWM/cycle timer.
//  N_CH independent channels share one register write port. Each channel has its own

---
 rtl/pwm_timer_pkg.sv | 11 +
 rtl/pwm_timer_mc_if.sv | 14 +
 rtl/pwm_timer_ch.sv | 142 ++++++++++++++
 rtl/pwm_timer_mc.sv | 42 ++++
 tb/tb_pwm_timer_mc.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_timer_pkg.sv
// pwm_timer_pkg: register offsets, CTRL bit indices and channel state encoding
package pwm_timer_pkg;
  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_DUTY   = 2'd1;
  localparam logic [1:0] REG_NCYC   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;
  localparam int CTRL_CONT  = 0;
  localparam int CTRL_INV   = 1;
  localparam int CTRL_ABORT = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ch_state_e;
endpackage

// File: rtl/pwm_timer_mc_if.sv
// pwm_timer_mc_if: register write port shared by all PWM channels
//   we     write strobe
//   addr   {channel, reg}
//   wdata  write data
interface pwm_timer_mc_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic                    we;
  logic [$clog2(N_CH)+1:0] addr;
  logic [CNT_W-1:0]        wdata;
  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/pwm_timer_ch.sv
// pwm_timer_ch: one PWM channel with shadow/active registers, FSM, counters and outputs
//   i_clk/i_rst_n              clock, synchronous active-low reset
//   i_start                    start request, honoured only in IDLE
//   i_we/i_reg/i_wdata         write port already decoded to this channel
//   o_pwm/o_timer_end/o_busy   registered PWM, one-shot completion flag, state != IDLE
module pwm_timer_ch
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int CYC_W    = 8,
  parameter int END_HOLD = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_we,
  input  logic [1:0]       i_reg,
  input  logic [CNT_W-1:0] i_wdata,
  output logic             o_pwm,
  output logic             o_timer_end,
  output logic             o_busy
);
  localparam int HW = $clog2(END_HOLD + 1);
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] per_s_q, per_s_d, duty_s_q, duty_s_d;
  logic [CNT_W-1:0] per_a_q, per_a_d, duty_a_q, duty_a_d;
  logic [CNT_W-1:0] inner_q, inner_d, per_eff;
  logic [CYC_W-1:0] ncyc_s_q, ncyc_s_d, ncyc_a_q, ncyc_a_d, cyc_q, cyc_d, cyc_inc;
  logic [HW-1:0]    hold_q, hold_d;
  logic             cont_s_q, cont_s_d, inv_s_q, inv_s_d;
  logic             cont_a_q, cont_a_d, inv_a_q, inv_a_d;
  logic             pwm_q, pwm_d, end_q, end_d;
  logic             wr_ctrl, abort, wrap;
  assign wr_ctrl  = i_we && i_reg == REG_CTRL;
  assign abort    = wr_ctrl && i_wdata[CTRL_ABORT];
  assign per_s_d  = (i_we && i_reg == REG_PERIOD) ? i_wdata : per_s_q;
  assign duty_s_d = (i_we && i_reg == REG_DUTY) ? i_wdata : duty_s_q;
  assign ncyc_s_d = (i_we && i_reg == REG_NCYC) ? i_wdata[CYC_W-1:0] : ncyc_s_q;
  assign cont_s_d = wr_ctrl ? i_wdata[CTRL_CONT] : cont_s_q;
  assign inv_s_d  = wr_ctrl ? i_wdata[CTRL_INV] : inv_s_q;
  // A zero period behaves as a one-clock period
  assign per_eff  = (per_a_q == '0) ? CNT_W'(1) : per_a_q;
  assign wrap     = inner_q == per_eff - CNT_W'(1);
  assign cyc_inc  = cyc_q + CYC_W'(1);
  always_comb begin
    state_d  = state_q;
    per_a_d  = per_a_q;
    duty_a_d = duty_a_q;
    ncyc_a_d = ncyc_a_q;
    cont_a_d = cont_a_q;
    inv_a_d  = inv_a_q;
    inner_d  = inner_q;
    cyc_d    = cyc_q;
    hold_d   = hold_q;
    pwm_d    = inv_a_q;
    end_d    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      inner_d = '0;
      cyc_d   = '0;
      hold_d  = '0;
    end else if (state_q == IDLE) begin
      // Start loads the forwarded shadows so a same-cycle write takes effect
      if (i_start) begin
        state_d  = RUN;
        per_a_d  = per_s_d;
        duty_a_d = duty_s_d;
        ncyc_a_d = ncyc_s_d;
        cont_a_d = cont_s_d;
        inv_a_d  = inv_s_d;
        inner_d  = '0;
        cyc_d    = '0;
      end
    end else if (state_q == RUN) begin
      // A zero-cycle one-shot finishes without emitting any PWM value
      if (!cont_a_q && ncyc_a_q == '0) begin
        state_d = DONE;
        hold_d  = '0;
      end else begin
        pwm_d   = (inner_q >= duty_a_q) ^ inv_a_q;
        inner_d = wrap ? '0 : inner_q + CNT_W'(1);
        if (wrap) begin
          cyc_d    = cyc_inc;
          per_a_d  = per_s_q;
          duty_a_d = duty_s_q;
          inv_a_d  = inv_s_q;
          if (!cont_a_q && cyc_inc == ncyc_a_q) begin
            state_d = DONE;
            hold_d  = '0;
          end
        end
      end
    end else begin
      end_d  = hold_q != HW'(END_HOLD);
      hold_d = hold_q + HW'(1);
      if (hold_q == HW'(END_HOLD)) begin
        state_d = IDLE;
        hold_d  = '0;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      per_s_q  <= '0;
      duty_s_q <= '0;
      ncyc_s_q <= '0;
      cont_s_q <= 1'b0;
      inv_s_q  <= 1'b0;
      per_a_q  <= '0;
      duty_a_q <= '0;
      ncyc_a_q <= '0;
      cont_a_q <= 1'b0;
      inv_a_q  <= 1'b0;
      inner_q  <= '0;
      cyc_q    <= '0;
      hold_q   <= '0;
      pwm_q    <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_s_q  <= per_s_d;
      duty_s_q <= duty_s_d;
      ncyc_s_q <= ncyc_s_d;
      cont_s_q <= cont_s_d;
      inv_s_q  <= inv_s_d;
      per_a_q  <= per_a_d;
      duty_a_q <= duty_a_d;
      ncyc_a_q <= ncyc_a_d;
      cont_a_q <= cont_a_d;
      inv_a_q  <= inv_a_d;
      inner_q  <= inner_d;
      cyc_q    <= cyc_d;
      hold_q   <= hold_d;
      pwm_q    <= pwm_d;
      end_q    <= end_d;
    end
  end
  assign o_pwm       = pwm_q;
  assign o_timer_end = end_q;
  assign o_busy      = state_q != IDLE;
endmodule

// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: N_CH-channel PWM timer sharing one register write port
//   i_clk/i_rst_n              clock, synchronous active-low reset
//   i_start                    per-channel start requests
//   bus                        write port, addr = {channel, reg}
//   o_pwm/o_timer_end/o_busy   per-channel outputs
module pwm_timer_mc
  import pwm_timer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int CYC_W    = 8,
  parameter int END_HOLD = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_start,
  pwm_timer_mc_if.slave     bus,
  output logic [N_CH-1:0]   o_pwm,
  output logic [N_CH-1:0]   o_timer_end,
  output logic [N_CH-1:0]   o_busy
);
  localparam int CHW = $clog2(N_CH);
  logic [CHW-1:0] ch_sel;
  assign ch_sel = bus.addr[CHW+1:2];
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pwm_timer_ch #(
      .CNT_W    (CNT_W),
      .CYC_W    (CYC_W),
      .END_HOLD (END_HOLD)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start[c]),
      .i_we        (bus.we && ch_sel == CHW'(c)),
      .i_reg       (bus.addr[1:0]),
      .i_wdata     (bus.wdata),
      .o_pwm       (o_pwm[c]),
      .o_timer_end (o_timer_end[c]),
      .o_busy      (o_busy[c])
    );
  end
endmodule

// File: tb/tb_pwm_timer_mc.sv
// tb_pwm_timer_mc: randomized self-checking bench for pwm_timer_mc
module tb_pwm_timer_mc;
  localparam int N_CH = 4, CNT_W = 16, CYC_W = 8, END_HOLD = 10;
  localparam int AW = $clog2(N_CH) + 2;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [N_CH-1:0] i_start = '0;
  logic [N_CH-1:0] o_pwm, o_timer_end, o_busy;
  int checks = 0;
  int errors = 0;
  pwm_timer_mc_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();
  pwm_timer_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .CYC_W(CYC_W), .END_HOLD(END_HOLD)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .bus         (bus),
    .o_pwm       (o_pwm),
    .o_timer_end (o_timer_end),
    .o_busy      (o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic wr(input int ch, input int r, input int d);
    bus.we = 1'b1;
    bus.addr = AW'(ch * 4 + r);
    bus.wdata = CNT_W'(d);
    tick();
    bus.we = 1'b0;
  endtask
  task automatic cfg(input int ch, input int p, input int d, input int n, input int cont, input int inv);
    wr(ch, 0, p);
    wr(ch, 1, d);
    wr(ch, 2, n);
    wr(ch, 3, cont + 2 * inv);
  endtask
  // Clocks spent in RUN for a one-shot: NCYC whole periods, or one clock when NCYC is 0
  function automatic int run_len(input int p, input int n);
    return (n == 0) ? 1 : n * ((p == 0) ? 1 : p);
  endfunction
  // Expected {busy, timer_end, pwm} k clocks after the start edge, shadows unchanged during the run
  function automatic logic [2:0] model(input int k, input int p, input int d, input int n,
                                       input int cont, input int inv);
    int pe, r;
    logic act, lvl;
    pe  = (p == 0) ? 1 : p;
    r   = (cont != 0) ? 32'h4000_0000 : run_len(p, n);
    lvl = inv != 0;
    act = (n == 0 && cont == 0) ? 1'b0 : ((k - 1) % pe >= d);
    if (k <= r) return {2'b10, act ^ lvl};
    if (k <= r + END_HOLD) return {2'b11, lvl};
    return {2'b00, lvl};
  endfunction
  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    checks++; if (o_pwm !== '0) begin errors++; $display("FAIL reset_pwm got %b expected 0000", o_pwm); end
    checks++; if (o_timer_end !== '0) begin errors++; $display("FAIL reset_end got %b expected 0000", o_timer_end); end
    checks++; if (o_busy !== '0) begin errors++; $display("FAIL reset_busy got %b expected 0000", o_busy); end
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_busy !== '0) begin errors++; $display("FAIL reset_idle got busy %b expected 0000", o_busy); end
  endtask
  task automatic test_oneshot();
    int p, d, n, inv, r, j;
    logic [2:0] exp, got;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        p = 4; d = 1; n = 2; inv = 0;
      end else begin
        p = $urandom_range(1, 6); d = $urandom_range(0, 7); n = $urandom_range(1, 3); inv = $urandom_range(0, 1);
      end
      cfg(0, p, d, n, 0, inv);
      r = run_len(p, n);
      j = $urandom_range(1, r + END_HOLD);
      i_start[0] = 1'b1;
      tick();
      i_start[0] = 1'b0;
      for (int k = 1; k <= r + END_HOLD + 2; k++) begin
        if (it > 0 && k == j) i_start[0] = 1'b1;
        tick();
        i_start[0] = 1'b0;
        exp = model(k, p, d, n, 0, inv);
        got = {o_busy[0], o_timer_end[0], o_pwm[0]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL oneshot it%0d k=%0d p=%0d d=%0d n=%0d inv=%0d busy/end/pwm got %b expected %b", it, k, p, d, n, inv, got, exp);
        end
      end
    end
  endtask
  task automatic test_cont();
    int p, d, inv;
    logic [2:0] exp, got;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        p = 5; d = 2; inv = 1;
      end else begin
        p = $urandom_range(1, 7); d = $urandom_range(0, 8); inv = $urandom_range(0, 1);
      end
      cfg(1, p, d, $urandom_range(0, 2), 1, inv);
      i_start[1] = 1'b1;
      tick();
      i_start[1] = 1'b0;
      for (int k = 1; k <= 4 * p + 3; k++) begin
        tick();
        exp = model(k, p, d, 0, 1, inv);
        got = {o_busy[1], o_timer_end[1], o_pwm[1]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cont it%0d k=%0d p=%0d d=%0d inv=%0d busy/end/pwm got %b expected %b", it, k, p, d, inv, got, exp);
        end
      end
      wr(1, 3, 4);
      got = {o_busy[1], o_timer_end[1], o_pwm[1]};
      exp = {2'b00, inv != 0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL cont_abort it%0d busy/end/pwm got %b expected %b", it, got, exp); end
    end
  endtask
  task automatic test_boundary();
    int nd, wk, dd;
    logic exp;
    for (int it = 0; it < 3; it++) begin
      nd = (it == 0) ? 2 : $urandom_range(0, 9);
      wk = (it == 0) ? 6 : $urandom_range(1, 7);
      cfg(2, 8, 4, 0, 1, 0);
      i_start[2] = 1'b1;
      tick();
      i_start[2] = 1'b0;
      for (int k = 1; k <= 24; k++) begin
        if (k == wk) begin
          bus.we = 1'b1;
          bus.addr = AW'(2 * 4 + 1);
          bus.wdata = CNT_W'(nd);
        end
        tick();
        bus.we = 1'b0;
        dd = (k <= 8) ? 4 : nd;
        exp = (k - 1) % 8 >= dd;
        checks++;
        if (o_pwm[2] !== exp) begin
          errors++;
          $display("FAIL boundary it%0d k=%0d new_duty=%0d write_k=%0d pwm got %b expected %b", it, k, nd, wk, o_pwm[2], exp);
        end
      end
      wr(2, 3, 4);
    end
  endtask
  task automatic test_abort();
    logic [2:0] exp, got;
    cfg(3, 6, 3, 5, 1, 0);
    i_start[3] = 1'b1;
    tick();
    i_start[3] = 1'b0;
    repeat (4) tick();
    checks++; if (o_busy[3] !== 1'b1) begin errors++; $display("FAIL abort_pre busy got %b expected 1", o_busy[3]); end
    bus.we = 1'b1;
    bus.addr = AW'(3 * 4 + 3);
    bus.wdata = CNT_W'(4);
    i_start[3] = 1'b1;
    tick();
    bus.we = 1'b0;
    i_start[3] = 1'b0;
    got = {o_busy[3], o_timer_end[3], o_pwm[3]};
    checks++; if (got !== 3'b000) begin errors++; $display("FAIL abort_run busy/end/pwm got %b expected 000", got); end
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (o_busy[3] !== 1'b0 || o_timer_end[3] !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle k=%0d busy/end got %b%b expected 00", k, o_busy[3], o_timer_end[3]);
      end
    end
    cfg(3, 2, 1, 1, 0, 1);
    i_start[3] = 1'b1;
    tick();
    i_start[3] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = model(k, 2, 1, 1, 0, 1);
      got = {o_busy[3], o_timer_end[3], o_pwm[3]};
      checks++; if (got !== exp) begin errors++; $display("FAIL abort_done_pre k=%0d got %b expected %b", k, got, exp); end
    end
    wr(3, 3, 4);
    got = {o_busy[3], o_timer_end[3], o_pwm[3]};
    checks++; if (got !== 3'b001) begin errors++; $display("FAIL abort_done busy/end/pwm got %b expected 001", got); end
  endtask
  task automatic test_edges();
    int tp[5] = '{4, 8, 3, 0, 0};
    int td[5] = '{0, 9, 1, 0, 1};
    int tn[5] = '{2, 1, 0, 3, 2};
    logic [2:0] exp, got;
    for (int e = 0; e < 5; e++) begin
      cfg(0, tp[e], td[e], tn[e], 0, 0);
      i_start[0] = 1'b1;
      tick();
      i_start[0] = 1'b0;
      for (int k = 1; k <= run_len(tp[e], tn[e]) + END_HOLD + 2; k++) begin
        tick();
        exp = model(k, tp[e], td[e], tn[e], 0, 0);
        got = {o_busy[0], o_timer_end[0], o_pwm[0]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL edge%0d k=%0d p=%0d d=%0d n=%0d busy/end/pwm got %b expected %b", e, k, tp[e], td[e], tn[e], got, exp);
        end
      end
    end
  endtask
  task automatic test_forward();
    logic [2:0] exp, got;
    for (int it = 0; it < 2; it++) begin
      cfg(0, 4, 3, 1, 0, 0);
      bus.we = 1'b1;
      bus.addr = AW'((it == 0) ? 1 : 3);
      bus.wdata = CNT_W'((it == 0) ? 1 : 2);
      i_start[0] = 1'b1;
      tick();
      bus.we = 1'b0;
      i_start[0] = 1'b0;
      for (int k = 1; k <= 4 + END_HOLD + 2; k++) begin
        tick();
        exp = (it == 0) ? model(k, 4, 1, 1, 0, 0) : model(k, 4, 3, 1, 0, 1);
        got = {o_busy[0], o_timer_end[0], o_pwm[0]};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL forward it%0d k=%0d got %b expected %b", it, k, got, exp); end
      end
    end
  endtask
  task automatic test_back_to_back();
    int p[N_CH], d[N_CH], n[N_CH], inv[N_CH];
    int last;
    logic [2:0] exp, got;
    for (int it = 0; it < 4; it++) begin
      last = 0;
      for (int c = 0; c < N_CH; c++) begin
        p[c] = $urandom_range(0, 5); d[c] = $urandom_range(0, 6); n[c] = $urandom_range(0, 3); inv[c] = $urandom_range(0, 1);
        cfg(c, p[c], d[c], n[c], 0, inv[c]);
        if (run_len(p[c], n[c]) + END_HOLD + 2 > last) last = run_len(p[c], n[c]) + END_HOLD + 2;
      end
      i_start = '1;
      tick();
      i_start = '0;
      for (int k = 1; k <= last; k++) begin
        tick();
        for (int c = 0; c < N_CH; c++) begin
          exp = model(k, p[c], d[c], n[c], 0, inv[c]);
          got = {o_busy[c], o_timer_end[c], o_pwm[c]};
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL parallel it%0d ch%0d k=%0d p=%0d d=%0d n=%0d inv=%0d got %b expected %b", it, c, k, p[c], d[c], n[c], inv[c], got, exp);
          end
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [2:0] exp, got;
    for (int c = 0; c < N_CH; c++) cfg(c, 3, 1, 2, 1, c % 2);
    i_start = '1;
    tick();
    i_start = '0;
    repeat (5) tick();
    checks++; if (o_busy !== '1) begin errors++; $display("FAIL rst_mid_pre busy got %b expected 1111", o_busy); end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    checks++; if (o_pwm !== '0) begin errors++; $display("FAIL rst_mid_pwm got %b expected 0000", o_pwm); end
    checks++; if (o_timer_end !== '0) begin errors++; $display("FAIL rst_mid_end got %b expected 0000", o_timer_end); end
    checks++; if (o_busy !== '0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0000", o_busy); end
    i_start[0] = 1'b1;
    tick();
    i_start[0] = 1'b0;
    for (int k = 1; k <= END_HOLD + 3; k++) begin
      tick();
      exp = model(k, 0, 0, 0, 0, 0);
      got = {o_busy[0], o_timer_end[0], o_pwm[0]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_cleared k=%0d got %b expected %b", k, got, exp); end
      checks++;
      if (o_busy[N_CH-1:1] !== '0) begin errors++; $display("FAIL rst_others k=%0d busy got %b expected 000", k, o_busy[N_CH-1:1]); end
    end
  endtask
  initial begin
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    test_reset();
    test_oneshot();
    test_cont();
    test_boundary();
    test_abort();
    test_edges();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
